// File: rtl/serial_div_pkg.sv
// Shared types and modular arithmetic helper for the serial divisibility checker.
package serial_div_pkg;

  typedef enum logic [0:0] {IDLE, RUN} state_t;

  // Operand width that holds any sum of two residues below 256.
  localparam int unsigned OP_W = 9;

  // (a + b) mod m, valid when a + b < 2*m.
  function automatic logic [OP_W-1:0] mod_double_add(input logic [OP_W-1:0] a,
                                                     input logic [OP_W-1:0] b,
                                                     input logic [OP_W-1:0] m);
    logic [OP_W-1:0] t;
    t = a + b;
    return (t >= m) ? (t - m) : t;
  endfunction

endpackage

// File: rtl/serial_mod_step.sv
// One-bit remainder update for either bit order; purely combinational.
module serial_mod_step
  import serial_div_pkg::*;
#(
  parameter int unsigned DIVISOR   = 3,
  parameter bit          MSB_FIRST = 1'b1,
  parameter int unsigned REM_W     = 2
) (
  input  logic [REM_W-1:0] rem,
  input  logic [REM_W-1:0] w,
  input  logic             x,
  output logic [REM_W-1:0] rem_next,
  output logic [REM_W-1:0] w_next
);

  logic [OP_W-1:0] rem_e, w_e, x_e, div_e, rem_sum, w_sum;

  always_comb begin
    rem_e = OP_W'(rem);
    w_e   = OP_W'(w);
    x_e   = OP_W'(x);
    div_e = OP_W'(DIVISOR);
    if (MSB_FIRST) begin
      rem_sum = mod_double_add(rem_e, rem_e + x_e, div_e);
      w_sum   = w_e;
    end else begin
      rem_sum = mod_double_add(rem_e, x ? w_e : '0, div_e);
      w_sum   = mod_double_add(w_e, w_e, div_e);
    end
    rem_next = REM_W'(rem_sum);
    w_next   = REM_W'(w_sum);
  end

endmodule

// File: rtl/serial_div_checker.sv
// Framed serial divisibility checker: running remainder modulo DIVISOR with registered status.
module serial_div_checker
  import serial_div_pkg::*;
#(
  parameter int unsigned DIVISOR   = 3,
  parameter bit          MSB_FIRST = 1'b1,
  parameter int unsigned MAX_BITS  = 32,
  localparam int unsigned REM_W    = ($clog2(DIVISOR) > 1) ? $clog2(DIVISOR) : 1,
  localparam int unsigned CNT_W    = $clog2(MAX_BITS + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             valid_i,
  input  logic             sof_i,
  input  logic             eof_i,
  input  logic             x_i,
  output logic [REM_W-1:0] rem_o,
  output logic             div_o,
  output logic             rem_valid_o,
  output logic             done_o,
  output logic             abort_o,
  output logic [CNT_W-1:0] count_o,
  output logic             overflow_o
);

  state_t state_q, state_d;
  logic accept, abort_d, done_d;

  logic [REM_W-1:0] rem_q, w_q, rem_d, w_d, base_rem, base_w;
  logic [CNT_W-1:0] cnt_q, cnt_d, base_cnt;
  logic             ovf_q, ovf_d, base_ovf;
  logic             rem_valid_q, done_q, abort_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (accept) state_d = eof_i ? IDLE : RUN;
  end

  always_comb begin
    accept  = valid_i && ((state_q == RUN) || sof_i);
    abort_d = accept && sof_i && (state_q == RUN);
    done_d  = accept && eof_i;
  end

  // A sof bit starts from an empty frame before its own bit is applied.
  always_comb begin
    base_rem = sof_i ? '0 : rem_q;
    base_w   = sof_i ? REM_W'(1) : w_q;
    base_cnt = sof_i ? '0 : cnt_q;
    base_ovf = sof_i ? 1'b0 : ovf_q;
    if (base_cnt == CNT_W'(MAX_BITS)) begin
      cnt_d = base_cnt;
      ovf_d = 1'b1;
    end else begin
      cnt_d = base_cnt + CNT_W'(1);
      ovf_d = base_ovf;
    end
  end

  serial_mod_step #(
    .DIVISOR  (DIVISOR),
    .MSB_FIRST(MSB_FIRST),
    .REM_W    (REM_W)
  ) u_step (
    .rem     (base_rem),
    .w       (base_w),
    .x       (x_i),
    .rem_next(rem_d),
    .w_next  (w_d)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rem_q       <= '0;
      w_q         <= REM_W'(1);
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      rem_valid_q <= 1'b0;
      done_q      <= 1'b0;
      abort_q     <= 1'b0;
    end else begin
      rem_valid_q <= accept;
      done_q      <= done_d;
      abort_q     <= abort_d;
      if (accept) begin
        rem_q <= rem_d;
        w_q   <= w_d;
        cnt_q <= cnt_d;
        ovf_q <= ovf_d;
      end
    end
  end

  assign rem_o       = rem_q;
  assign div_o       = (rem_q == '0);
  assign rem_valid_o = rem_valid_q;
  assign done_o      = done_q;
  assign abort_o     = abort_q;
  assign count_o     = cnt_q;
  assign overflow_o  = ovf_q;

endmodule

// File: tb/tb_serial_div_checker.sv
// Directed bench: four configurations share one stimulus stream, each checked where relevant.
module tb_serial_div_checker;

  logic clk = 1'b0;
  logic reset_n, valid, sof, eof, x;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // a: D=3 MSB, b: D=5 MSB, c: D=3 LSB, d: D=3 MSB MAX_BITS=4
  logic [1:0] a_rem, c_rem, d_rem;
  logic [2:0] b_rem;
  logic [5:0] a_cnt, b_cnt, c_cnt;
  logic [2:0] d_cnt;
  logic a_div, a_rv, a_done, a_abort, a_ovf;
  logic b_div, b_rv, b_done, b_abort, b_ovf;
  logic c_div, c_rv, c_done, c_abort, c_ovf;
  logic d_div, d_rv, d_done, d_abort, d_ovf;

  serial_div_checker #(.DIVISOR(3), .MSB_FIRST(1'b1), .MAX_BITS(32)) u_a (
    .clk(clk), .reset_n(reset_n), .valid_i(valid), .sof_i(sof), .eof_i(eof), .x_i(x),
    .rem_o(a_rem), .div_o(a_div), .rem_valid_o(a_rv), .done_o(a_done), .abort_o(a_abort),
    .count_o(a_cnt), .overflow_o(a_ovf)
  );
  serial_div_checker #(.DIVISOR(5), .MSB_FIRST(1'b1), .MAX_BITS(32)) u_b (
    .clk(clk), .reset_n(reset_n), .valid_i(valid), .sof_i(sof), .eof_i(eof), .x_i(x),
    .rem_o(b_rem), .div_o(b_div), .rem_valid_o(b_rv), .done_o(b_done), .abort_o(b_abort),
    .count_o(b_cnt), .overflow_o(b_ovf)
  );
  serial_div_checker #(.DIVISOR(3), .MSB_FIRST(1'b0), .MAX_BITS(32)) u_c (
    .clk(clk), .reset_n(reset_n), .valid_i(valid), .sof_i(sof), .eof_i(eof), .x_i(x),
    .rem_o(c_rem), .div_o(c_div), .rem_valid_o(c_rv), .done_o(c_done), .abort_o(c_abort),
    .count_o(c_cnt), .overflow_o(c_ovf)
  );
  serial_div_checker #(.DIVISOR(3), .MSB_FIRST(1'b1), .MAX_BITS(4)) u_d (
    .clk(clk), .reset_n(reset_n), .valid_i(valid), .sof_i(sof), .eof_i(eof), .x_i(x),
    .rem_o(d_rem), .div_o(d_div), .rem_valid_o(d_rv), .done_o(d_done), .abort_o(d_abort),
    .count_o(d_cnt), .overflow_o(d_ovf)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Present one bit (or a gap when v=0) for one cycle; return #1 after the edge.
  task automatic step(input logic v, input logic s, input logic e, input logic b);
    @(negedge clk);
    valid = v; sof = s; eof = e; x = b;
    @(posedge clk);
    #1;
    valid = 1'b0; sof = 1'b0; eof = 1'b0; x = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; valid = 1'b0; sof = 1'b0; eof = 1'b0; x = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_rem", 32'(a_rem), 0);
    check("rst_div", 32'(a_div), 1);
    check("rst_cnt", 32'(a_cnt), 0);
    check("rst_ovf", 32'(a_ovf), 0);
    check("rst_pulses", 32'({a_rv, a_done, a_abort}), 0);
    @(negedge clk);
    reset_n = 1'b1;

    // Valid bit without sof in IDLE is ignored.
    step(1, 0, 0, 1);
    check("idle_rem", 32'(a_rem), 0);
    check("idle_cnt", 32'(a_cnt), 0);
    check("idle_rv", 32'(a_rv), 0);

    // D=3 MSB frame 1,1,0
    step(1, 1, 0, 1);
    check("t1_rem0", 32'(a_rem), 1);
    check("t1_rv0", 32'(a_rv), 1);
    check("t1_done0", 32'(a_done), 0);
    step(1, 0, 0, 1);
    check("t1_rem1", 32'(a_rem), 0);
    step(1, 0, 1, 0);
    check("t1_rem2", 32'(a_rem), 0);
    check("t1_div", 32'(a_div), 1);
    check("t1_done", 32'(a_done), 1);
    check("t1_cnt", 32'(a_cnt), 3);
    step(1, 0, 0, 1);
    check("t1_done_once", 32'(a_done), 0);
    check("t1_hold_rem", 32'(a_rem), 0);
    check("t1_hold_cnt", 32'(a_cnt), 3);

    // D=5 MSB frame 1,0,1,1 ; D=3 LSB sees 1,0,1 prefix
    step(1, 1, 0, 1);
    check("t2_rem0", 32'(b_rem), 1);
    check("t3_rem0", 32'(c_rem), 1);
    step(1, 0, 0, 0);
    check("t2_rem1", 32'(b_rem), 2);
    check("t3_rem1", 32'(c_rem), 1);
    step(1, 0, 0, 1);
    check("t2_rem2", 32'(b_rem), 0);
    check("t2_div2", 32'(b_div), 1);
    check("t3_rem2", 32'(c_rem), 2);
    check("t3_div", 32'(c_div), 0);
    step(1, 0, 1, 1);
    check("t2_rem3", 32'(b_rem), 1);
    check("t2_div", 32'(b_div), 0);
    check("t2_done", 32'(b_done), 1);

    // Six-bit frame of ones on MAX_BITS=4 instance
    step(1, 1, 0, 1);
    check("t4_cnt1", 32'(d_cnt), 1);
    step(1, 0, 0, 1);
    step(1, 0, 0, 1);
    step(1, 0, 0, 1);
    check("t4_cnt4", 32'(d_cnt), 4);
    check("t4_ovf4", 32'(d_ovf), 0);
    step(1, 0, 0, 1);
    check("t4_cnt5", 32'(d_cnt), 4);
    check("t4_ovf5", 32'(d_ovf), 1);
    check("t4_rem5", 32'(d_rem), 1);
    step(1, 0, 1, 1);
    check("t4_cnt6", 32'(d_cnt), 4);
    check("t4_ovf6", 32'(d_ovf), 1);
    check("t4_rem6", 32'(d_rem), 0);
    check("t4_big_cnt", 32'(a_cnt), 6);
    check("t4_big_ovf", 32'(a_ovf), 0);

    // Gaps then restart by sof
    step(1, 1, 0, 1);
    step(0, 1, 1, 1);
    check("t5_gap_rem", 32'(a_rem), 1);
    check("t5_gap_cnt", 32'(a_cnt), 1);
    check("t5_gap_rv", 32'(a_rv), 0);
    step(1, 0, 0, 1);
    check("t5_rem2", 32'(a_rem), 0);
    check("t5_cnt2", 32'(a_cnt), 2);
    step(0, 0, 0, 1);
    check("t5_gap2_rem", 32'(a_rem), 0);
    check("t5_gap2_done", 32'(a_done), 0);
    step(1, 1, 0, 1);
    check("t5_abort", 32'(a_abort), 1);
    check("t5_rst_rem", 32'(a_rem), 1);
    check("t5_rst_cnt", 32'(a_cnt), 1);
    check("t5_no_done", 32'(a_done), 0);
    step(1, 0, 1, 0);
    check("t5_abort_once", 32'(a_abort), 0);
    check("t5_end_rem", 32'(a_rem), 2);
    check("t5_end_done", 32'(a_done), 1);

    // Async reset mid-frame
    step(1, 1, 0, 1);
    step(1, 0, 0, 1);
    step(1, 0, 0, 1);
    check("t6_pre_cnt", 32'(a_cnt), 3);
    reset_n = 1'b0;
    #1;
    check("t6_async_rem", 32'(a_rem), 0);
    check("t6_async_div", 32'(a_div), 1);
    check("t6_async_cnt", 32'(a_cnt), 0);
    check("t6_async_rv", 32'(a_rv), 0);
    @(negedge clk);
    reset_n = 1'b1;
    step(1, 0, 0, 1);
    check("t6_ign_rem", 32'(a_rem), 0);
    check("t6_ign_cnt", 32'(a_cnt), 0);
    check("t6_ign_pulse", 32'({a_rv, a_done, a_abort}), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
